part_clock_ctrl: RTL and testbench
==================================

# part_clock_ctrl

Cycle-level driver for the device under test inside `part_tester`. It sits directly downstream of the command processor. It turns decoded execute, free-run and scan-shift requests into the part's clock, `test_se` and `test_tm` pins, and streams scan bits between the command processor and the part's scan chain. The command processor decodes the UART byte stream and hands each command here with a 16-bit length. This block owns every edge of the part clock.

## Interface
- `HALF`, default 4: half-period of the part clock in `clk` cycles; must be ≥1.
- `clk` in 1: system clock, 50 MHz.
- `rstn` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: operation code.
  - 0: EXEC, run `cmd_len` part cycles.
  - 1: FREE, run until `pause`.
  - 2: SHIFT_IN, load scan chain.
  - 3: SHIFT_OUT, unload scan chain.
- `cmd_len` in 16: cycle count or bit count; ignored for FREE.
- `pause` in 1: level; stops FREE.
- `sin_valid` in 1 / `sin_bit` in 1 / `sin_ready` out 1: scan-in bit handshake.
- `sout_valid` out 1 / `sout_bit` out 1 / `sout_ready` in 1: scan-out bit handshake.
- `done` out 1: one-cycle pulse when a command completes.
- `cycles` out 16: part clock rising edges issued in the current or last command.
- `part_clk` out 1: part clock.
- `part_test_se` out 1: part scan enable.
- `part_test_tm` out 1: part test mode.
- `part_scan_in` out 1: part scan input.
- `part_scan_out` in 1: part scan output.

## Operation
- **States:** IDLE, LOW, HIGH, WAIT_IN, WAIT_OUT, DONE.
- **Command accept:** a command is accepted on a `clk` edge where `cmd_valid && cmd_ready`. On accept, the block latches `cmd_op` and `cmd_len`, clears `cycles`, and loads `remaining = cmd_len`.
- **Zero length:** for EXEC, SHIFT_IN or SHIFT_OUT with `cmd_len == 0`, go straight to DONE. No clock edge is issued.
- **Part cycle:** a part cycle is LOW for HALF clks (`part_clk = 0`), then HIGH for HALF clks (`part_clk = 1`).
  - `cycles` increments on entry to HIGH.
  - `remaining` decrements on entry to HIGH.
- **EXEC:** from accept, enter LOW. At the end of HIGH:
  - if `remaining == 0`, go to DONE;
  - otherwise, go to LOW.
- **FREE:** same cycle sequence as EXEC; `remaining` is not used. `pause` is sampled only on the last clk of HIGH.
  - If `pause = 1`, go to DONE.
  - Otherwise, go to LOW.
  - A pause mid-cycle never truncates the current cycle.
- **SHIFT_IN:** enter WAIT_IN with `sin_ready = 1`.
  - On `sin_valid && sin_ready`, `part_scan_in <= sin_bit`, `sin_ready` drops, and the block runs one LOW/HIGH cycle.
  - At the end of HIGH: go to DONE if `remaining == 0`, else back to WAIT_IN.
- **SHIFT_OUT:** enter WAIT_OUT.
  - `sout_bit` holds `part_scan_out` as registered at WAIT_OUT entry. `sout_valid = 1`.
  - On `sout_ready`, `sout_valid` drops and one LOW/HIGH cycle runs.
  - At the end of HIGH: go to DONE if `remaining == 0`, else back to WAIT_OUT.
  - The first bit is presented before any shift edge.
- **Scan pins:** `part_test_se = part_test_tm = 1` in every state of a SHIFT_IN or SHIFT_OUT command, and 0 otherwise.
- **DONE:** lasts one clk with `done = 1`, then returns to IDLE.
- **Counter width:** `cycles` wraps modulo 2^16 in FREE.

## Timing
- **Reset values:** every output is 0 while `rstn = 0`. `state = IDLE`; `cmd_ready` asserts on the first clk after reset release.
- **Reset mid-command:** `rstn` low during a command aborts it immediately. `part_clk` returns low asynchronously. No `done` is issued.
- **EXEC latency:** from the accept edge to the `done` pulse is `2*HALF*cmd_len + 1` clks.
- **Zero-length latency:** `done` is asserted one clk after accept.
- **Rising edge:** `part_clk` rises exactly HALF clks after LOW entry.
- **Scan-in setup:** `part_scan_in` is stable ≥HALF clks before each rising edge and is held through HIGH.
- **Scan-out sampling:** `part_scan_out` is sampled only at WAIT_OUT entry.
- **Handshakes:** `sin_ready` and `sout_valid` are never high outside WAIT_IN and WAIT_OUT respectively.
- **Commands while busy:** `cmd_valid` is ignored while not IDLE.
- **Pause outside FREE:** `pause` is ignored outside FREE.

## Test plan
- **Reset:** reset, then EXEC `len` 4 with HALF = 4 → 4 part_clk pulses, each 4 clks high; `done` 33 clks after accept; `cycles = 4`; `test_se` stays 0.
- **Zero length:** EXEC `len` 0 → `done` on the next clk; `part_clk` never toggles; `cycles = 0`.
- **Free run:** FREE, assert `pause` mid-HIGH of the 6th cycle → the 6th cycle completes; `done` pulses; `cycles = 6`.
- **Scan in:** SHIFT_IN `len` 4 with bits 1,0,1,1 and a 3-clk gap before bit 2 → `part_scan_in` matches each bit at every rising edge; 4 edges; `test_se = test_tm = 1` throughout; `done` after the 4th HIGH.
- **Scan out:** SHIFT_OUT `len` 5 against a 5-bit shift-register model preloaded with 10110 → `sout_bit` sequence 1,0,1,1,0; exactly 5 edges; `sout_ready` stall honoured with no extra edge.
- **Reset mid-command:** assert `rstn` low during cycle 2 of EXEC `len` 10 → all outputs go to 0 asynchronously with no `done`; a subsequent EXEC `len` 2 behaves normally.

Source files
------------

// File: rtl/part_clock_ctrl.sv
// part_clock_ctrl
//   Drives the clock, scan-enable and test-mode pins of the part under test.
//   Decoded commands arrive from the command processor. The block runs part
//   clock cycles for execute and free-run commands. For scan commands it
//   exchanges one bit per part cycle with the command processor.
//
// Ports
//   clk, rstn                   system clock, async active-low reset
//   cmd_valid/ready/op/len      command request (op: EXEC, FREE, SHIFT_IN, SHIFT_OUT)
//   pause                       level input that stops a FREE command at a cycle boundary
//   sin_valid/ready/bit         scan-in bit stream from the command processor
//   sout_valid/ready/bit        scan-out bit stream to the command processor
//   done                        one-clk pulse when a command completes
//   cycles                      part clock rising edges in the current/last command
//   part_clk, part_test_se,
//   part_test_tm, part_scan_in  pins to the part
//   part_scan_out               scan chain output from the part
//
// Every output is a flop computed from the next state. All outputs therefore
// read 0 while reset is held, and cmd_ready rises on the first clk after release.
module part_clock_ctrl #(
   parameter int HALF = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_len,
   input  logic        pause,
   input  logic        sin_valid,
   input  logic        sin_bit,
   output logic        sin_ready,
   output logic        sout_valid,
   output logic        sout_bit,
   input  logic        sout_ready,
   output logic        done,
   output logic [15:0] cycles,
   output logic        part_clk,
   output logic        part_test_se,
   output logic        part_test_tm,
   output logic        part_scan_in,
   input  logic        part_scan_out
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOW, S_HIGH, S_WAIT_IN, S_WAIT_OUT, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_EXEC, OP_FREE, OP_SHIFT_IN, OP_SHIFT_OUT
   } op_t;

   state_t        state_q, state_d;
   op_t           op_q, op_d;
   logic [15:0]   rem_q, rem_d;
   logic [15:0]   cycles_q, cycles_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          scan_in_q, scan_in_d;
   logic          sout_bit_q, sout_bit_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          sin_ready_q, sin_ready_d;
   logic          sout_valid_q, sout_valid_d;
   logic          done_q, done_d;
   logic          part_clk_q, part_clk_d;
   logic          se_q, se_d;

   logic last_half;
   assign last_half = (cnt_q == LAST);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rem_d      = rem_q;
      cycles_d   = cycles_q;
      cnt_d      = cnt_q;
      scan_in_d  = scan_in_q;
      sout_bit_d = sout_bit_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d     = op_t'(cmd_op);
               rem_d    = cmd_len;
               cycles_d = '0;
               cnt_d    = '0;
               if (op_d != OP_FREE && cmd_len == 16'd0)
                  state_d = S_DONE;
               else if (op_d == OP_SHIFT_IN)
                  state_d = S_WAIT_IN;
               else if (op_d == OP_SHIFT_OUT)
                  state_d = S_WAIT_OUT;
               else
                  state_d = S_LOW;
            end
         end
         S_LOW: begin
            if (last_half) begin
               state_d  = S_HIGH;
               cnt_d    = '0;
               cycles_d = cycles_q + 16'd1;
               if (op_q != OP_FREE)
                  rem_d = rem_q - 16'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HIGH: begin
            if (last_half) begin
               cnt_d = '0;
               // pause is looked at only here, so a cycle is never cut short
               if (op_q == OP_FREE)
                  state_d = pause ? S_DONE : S_LOW;
               else if (rem_q == 16'd0)
                  state_d = S_DONE;
               else if (op_q == OP_SHIFT_IN)
                  state_d = S_WAIT_IN;
               else if (op_q == OP_SHIFT_OUT)
                  state_d = S_WAIT_OUT;
               else
                  state_d = S_LOW;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_IN: begin
            // bit is driven from LOW entry, giving HALF clks of setup
            if (sin_valid && sin_ready_q) begin
               scan_in_d = sin_bit;
               cnt_d     = '0;
               state_d   = S_LOW;
            end
         end
         S_WAIT_OUT: begin
            if (sout_ready && sout_valid_q) begin
               cnt_d   = '0;
               state_d = S_LOW;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // scan-out bit is captured once, on entry to WAIT_OUT
      if (state_d == S_WAIT_OUT && state_q != S_WAIT_OUT)
         sout_bit_d = part_scan_out;

      cmd_ready_d  = (state_d == S_IDLE);
      sin_ready_d  = (state_d == S_WAIT_IN);
      sout_valid_d = (state_d == S_WAIT_OUT);
      done_d       = (state_d == S_DONE);
      part_clk_d   = (state_d == S_HIGH);
      se_d         = (state_d != S_IDLE) &&
                     (op_d == OP_SHIFT_IN || op_d == OP_SHIFT_OUT);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         op_q         <= OP_EXEC;
         rem_q        <= '0;
         cycles_q     <= '0;
         cnt_q        <= '0;
         scan_in_q    <= 1'b0;
         sout_bit_q   <= 1'b0;
         cmd_ready_q  <= 1'b0;
         sin_ready_q  <= 1'b0;
         sout_valid_q <= 1'b0;
         done_q       <= 1'b0;
         part_clk_q   <= 1'b0;
         se_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         rem_q        <= rem_d;
         cycles_q     <= cycles_d;
         cnt_q        <= cnt_d;
         scan_in_q    <= scan_in_d;
         sout_bit_q   <= sout_bit_d;
         cmd_ready_q  <= cmd_ready_d;
         sin_ready_q  <= sin_ready_d;
         sout_valid_q <= sout_valid_d;
         done_q       <= done_d;
         part_clk_q   <= part_clk_d;
         se_q         <= se_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign sin_ready    = sin_ready_q;
   assign sout_valid   = sout_valid_q;
   assign sout_bit     = sout_bit_q;
   assign done         = done_q;
   assign cycles       = cycles_q;
   assign part_clk     = part_clk_q;
   assign part_test_se = se_q;
   assign part_test_tm = se_q;
   assign part_scan_in = scan_in_q;

endmodule

// File: tb/tb_part_clock_ctrl.sv
// Bench for part_clock_ctrl. The whole run is built up front as a list of
// per-clk vectors: the inputs to apply, and the outputs the part must see
// during that clk. Each part cycle is 2*H clks long. Handshake gaps and
// pause timing come from the stimulus tables. A single runner samples the
// outputs at each negedge, then drives that vector's inputs. Literal
// latency and edge-count expectations are checked at the end of the run.
module tb_part_clock_ctrl;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rstn, cmd_valid, cmd_ready, pause, sin_valid, sin_bit, sin_ready;
   logic        sout_valid, sout_bit, sout_ready, done, part_clk;
   logic        part_test_se, part_test_tm, part_scan_in, part_scan_out;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_len, cycles;

   always #10 clk = ~clk;

   part_clock_ctrl #(.HALF(H)) dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .pause(pause),
      .sin_valid(sin_valid), .sin_bit(sin_bit), .sin_ready(sin_ready),
      .sout_valid(sout_valid), .sout_bit(sout_bit), .sout_ready(sout_ready),
      .done(done), .cycles(cycles), .part_clk(part_clk),
      .part_test_se(part_test_se), .part_test_tm(part_test_tm),
      .part_scan_in(part_scan_in), .part_scan_out(part_scan_out)
   );

   // part's scan chain: shifts on each part clock rise while scan is enabled
   logic [4:0] chain = 5'b10110;
   assign part_scan_out = chain[4];
   always @(posedge part_clk) if (part_test_se) chain <= {chain[3:0], part_scan_in};

   typedef struct {
      bit rstn; bit cv; bit [1:0] op; bit [15:0] len;
      bit pause; bit siv; bit sib; bit sor;
   } in_t;
   typedef struct {
      bit rdy; bit dn; bit pclk; bit se; bit sinr; bit soutv; bit sbit; bit sin;
      bit [15:0] cyc;
   } exp_t;
   typedef struct { in_t in; exp_t ex; } vec_t;

   vec_t vq[$];
   int   n_vec = 0, n_bad = 0;
   int   m_cyc = 0;
   bit   m_sin = 0, m_sbit = 0, m_se = 0;
   int   done_idx[$], done_cyc[$], edge_idx[$];
   int   a_ex4, a_z, a_fr, a_so, a_si, a_rst, a_ex2, a_end;

   function automatic in_t nop();
      in_t r;
      r.rstn = 1; r.cv = 0; r.op = 0; r.len = 0;
      r.pause = 0; r.siv = 0; r.sib = 0; r.sor = 0;
      return r;
   endfunction

   task automatic put(input in_t in, input bit rdy, input bit dn, input bit pc,
                      input bit sinr, input bit soutv);
      vec_t v;
      v.in = in; v.ex.rdy = rdy; v.ex.dn = dn; v.ex.pclk = pc;
      v.ex.sinr = sinr; v.ex.soutv = soutv; v.ex.se = m_se;
      v.ex.sbit = m_sbit; v.ex.sin = m_sin; v.ex.cyc = 16'(m_cyc);
      vq.push_back(v);
   endtask

   task automatic reset_seq(input int n);
      in_t in;
      m_cyc = 0; m_sin = 0; m_sbit = 0; m_se = 0;
      in = nop(); in.rstn = 0;
      repeat (n) put(in, 0, 0, 0, 0, 0);
      put(nop(), 0, 0, 0, 0, 0);  // release: still the reset state this clk
   endtask

   task automatic idle(input int n);
      repeat (n) put(nop(), 1, 0, 0, 0, 0);
   endtask

   task automatic accept(input bit [1:0] op, input bit [15:0] len, output int idx);
      in_t in;
      in = nop(); in.cv = 1; in.op = op; in.len = len;
      idx = vq.size();
      put(in, 1, 0, 0, 0, 0);
      m_cyc = 0; m_se = op[1];
   endtask

   // one part cycle: H clks low then H clks high; cycles counts the rise
   task automatic cycle(input int pause_from, input bit cv_busy, input int rst_at);
      in_t in;
      for (int j = 0; j < 2*H; j++) begin
         if (j == H) m_cyc++;
         in = nop();
         in.pause = (j >= pause_from);
         in.cv = cv_busy; in.len = 16'd1;
         in.rstn = (j != rst_at);
         put(in, 0, 0, (j >= H), 0, 0);
         if (j == rst_at) return;
      end
   endtask

   task automatic finish_cmd();
      put(nop(), 0, 1, 0, 0, 0);
      m_se = 0;
   endtask

   task automatic exec(input int len, input int pause_from, input bit cv_busy,
                       output int idx);
      accept(2'd0, 16'(len), idx);
      repeat (len) cycle(pause_from, cv_busy, 2*H);
      finish_cmd();
   endtask

   task automatic free_run(input int ncyc, output int idx);
      accept(2'd1, 16'd3, idx);
      for (int c = 1; c <= ncyc; c++) cycle((c == ncyc) ? H + H/2 : 2*H, 0, 2*H);
      finish_cmd();
   endtask

   task automatic shift_in(output int idx);
      bit bits[4] = '{1, 0, 1, 1};
      int gaps[4] = '{0, 3, 0, 1};
      in_t in;
      accept(2'd2, 16'd4, idx);
      for (int i = 0; i < 4; i++) begin
         in = nop(); in.sib = ~bits[i];
         repeat (gaps[i]) put(in, 0, 0, 0, 1, 0);
         in.siv = 1; in.sib = bits[i];
         put(in, 0, 0, 0, 1, 0);
         m_sin = bits[i];
         cycle(2*H, 0, 2*H);
      end
      finish_cmd();
   endtask

   task automatic shift_out(output int idx);
      logic [4:0] pre = 5'b10110;
      int gaps[5] = '{0, 0, 2, 0, 1};
      in_t in;
      accept(2'd3, 16'd5, idx);
      for (int i = 0; i < 5; i++) begin
         m_sbit = pre[4-i];
         repeat (gaps[i]) put(nop(), 0, 0, 0, 0, 1);
         in = nop(); in.sor = 1;
         put(in, 0, 0, 0, 0, 1);
         cycle(2*H, 0, 2*H);
      end
      finish_cmd();
   endtask

   task automatic build();
      int dummy;
      reset_seq(3);          idle(2);
      exec(4, H, 1, a_ex4);  idle(2);   // pause and cmd_valid while busy are ignored
      exec(0, 2*H, 0, a_z);  idle(2);
      free_run(6, a_fr);     idle(2);
      shift_out(a_so);       idle(2);
      shift_in(a_si);        idle(2);
      accept(2'd0, 16'd10, a_rst);
      cycle(2*H, 0, 2*H);
      cycle(2*H, 0, H + 1);  // reset drops mid-HIGH of cycle 2
      reset_seq(2);          idle(2);
      exec(2, 2*H, 0, a_ex2); idle(3);
      a_end = vq.size();
      dummy = a_end;
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic compare(input exp_t e, input int i);
      chk($sformatf("v%0d cmd_ready", i),    int'(cmd_ready),    int'(e.rdy));
      chk($sformatf("v%0d done", i),         int'(done),         int'(e.dn));
      chk($sformatf("v%0d cycles", i),       int'(cycles),       int'(e.cyc));
      chk($sformatf("v%0d part_clk", i),     int'(part_clk),     int'(e.pclk));
      chk($sformatf("v%0d test_se", i),      int'(part_test_se), int'(e.se));
      chk($sformatf("v%0d test_tm", i),      int'(part_test_tm), int'(e.se));
      chk($sformatf("v%0d sin_ready", i),    int'(sin_ready),    int'(e.sinr));
      chk($sformatf("v%0d sout_valid", i),   int'(sout_valid),   int'(e.soutv));
      chk($sformatf("v%0d sout_bit", i),     int'(sout_bit),     int'(e.sbit));
      chk($sformatf("v%0d part_scan_in", i), int'(part_scan_in), int'(e.sin));
   endtask

   task automatic drive(input in_t in);
      rstn = in.rstn; cmd_valid = in.cv; cmd_op = in.op; cmd_len = in.len;
      pause = in.pause; sin_valid = in.siv; sin_bit = in.sib; sout_ready = in.sor;
   endtask

   function automatic int first_done(input int a);
      foreach (done_idx[k]) if (done_idx[k] > a) return k;
      return -1;
   endfunction

   function automatic int edges(input int a, input int b);
      int n = 0;
      foreach (edge_idx[k]) if (edge_idx[k] >= a && edge_idx[k] < b) n++;
      return n;
   endfunction

   task automatic chk_cmd(input string nm, input int a, input int lat, input int cyc);
      int k;
      k = first_done(a);
      chk({nm, "_latency"}, (k < 0) ? -1 : done_idx[k] - a, lat);
      chk({nm, "_cycles"},  (k < 0) ? -1 : done_cyc[k], cyc);
   endtask

   initial begin
      exp_t z;
      bit   prev_pc;
      int   k;
      z = '{default: 0};
      drive(nop());
      rstn = 0;
      build();
      prev_pc = 0;
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         compare(vq[i].ex, i);
         if (done === 1'b1) begin
            done_idx.push_back(i);
            done_cyc.push_back(int'(cycles));
         end
         if (part_clk === 1'b1 && !prev_pc) edge_idx.push_back(i);
         prev_pc = (part_clk === 1'b1);
         drive(vq[i].in);
         if (!vq[i].in.rstn) begin
            #1;
            compare(z, i);  // reset clears outputs without waiting for clk
            prev_pc = (part_clk === 1'b1);
         end
      end

      // EXEC 4 at HALF 4: 2*4*4+1 clks to done, 4 rises
      chk_cmd("exec4", a_ex4, 33, 4);
      chk("exec4_edges", edges(a_ex4, a_z), 4);
      chk_cmd("zero", a_z, 1, 0);
      chk("zero_edges", edges(a_z, a_fr), 0);
      chk_cmd("free", a_fr, 49, 6);
      chk("free_edges", edges(a_fr, a_so), 6);
      chk_cmd("shift_out", a_so, 49, 5);
      chk("shift_out_edges", edges(a_so, a_si), 5);
      chk_cmd("shift_in", a_si, 41, 4);
      chk("shift_in_edges", edges(a_si, a_rst), 4);
      chk("reset_edges", edges(a_rst, a_ex2), 2);
      k = first_done(a_rst);
      chk("reset_no_done", (k >= 0 && done_idx[k] < a_ex2) ? 1 : 0, 0);
      chk_cmd("exec2", a_ex2, 17, 2);
      chk("exec2_edges", edges(a_ex2, a_end), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
